// File: rtl/rom_rd_arbiter.sv
// rom_rd_arbiter
// Arbitrates two burst-read requesters onto a single synchronous ROM port.
// An accepted request becomes one ROM address per cycle for len+1 cycles.
// Each response returns to its requester after RD_LAT cycles, tagged with
// the requester that issued it.
//
// Optional feature: define ROM_ARB_RR_EN for round-robin arbitration.
// Without it, requester 0 has fixed priority.
//
// Parameters
//   ADDR_W  ROM word-address width
//   DATA_W  ROM data width
//   RD_LAT  ROM read latency in cycles, legal range 1..4
//
// Ports
//   rd_clk                sole clock, rising edge
//   rst_n                 asynchronous active-low reset
//   reqN_valid/reqN_ready burst request handshake (N = 0, 1)
//   reqN_addr             burst start address
//   reqN_len              burst length minus one
//   rspN_valid/rspN_data  read data returned to requester N
//   rom_addr              registered ROM address
//   rom_rd_data           ROM read data, RD_LAT cycles after rom_addr
//   busy                  burst in progress or responses in flight
module rom_rd_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [3:0]        req0_len,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [3:0]        req1_len,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic              owner;
    logic [3:0]        beat_cnt;
    logic [3:0]        len_q;
    logic              grant0;
    logic              grant1;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] own_pipe;

`ifdef ROM_ARB_RR_EN
    // last_grant == 1 means requester 1 won most recently.
    // Under contention, requester 0 therefore goes next.
    logic last_grant;

    assign grant0 = req0_valid & (~req1_valid | last_grant);

    // Remember who won each acceptance, so the other side wins the next tie.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (req0_ready | req1_ready) begin
            last_grant <= req1_ready;
        end
    end
`else
    assign grant0 = req0_valid;
`endif

    assign grant1 = req1_valid & ~grant0;

    // Ready is combinational from valid, but only while idle.
    // It is also held low during reset.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    // Burst FSM.
    // Acceptance loads the start address straight into rom_addr, so the
    // first beat goes out on the next cycle. The FSM then steps one word
    // per cycle and drops back to IDLE after the last beat. rom_addr keeps
    // its last value between bursts.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            beat_cnt <= 4'd0;
            len_q    <= 4'd0;
            rom_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        state    <= BURST;
                        owner    <= req1_ready;
                        beat_cnt <= 4'd0;
                        rom_addr <= req1_ready ? req1_addr : req0_addr;
                        len_q    <= req1_ready ? req1_len : req0_len;
                    end
                end
                BURST: begin
                    if (beat_cnt == len_q) begin
                        state <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                        rom_addr <= rom_addr + ADDR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue-valid and owner tag travel alongside the ROM's read latency.
    // Stage RD_LAT-1 lines up with rom_rd_data for the beat issued
    // RD_LAT cycles earlier.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe[0] <= (state == BURST);
            own_pipe[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
        end
    end

    assign rsp0_valid = vld_pipe[RD_LAT-1] & ~own_pipe[RD_LAT-1];
    assign rsp1_valid = vld_pipe[RD_LAT-1] &  own_pipe[RD_LAT-1];
    assign rsp0_data  = rom_rd_data;
    assign rsp1_data  = rom_rd_data;
    assign busy       = (state == BURST) | (|vld_pipe);

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb_rom_rd_arbiter
// Self-checking bench for rom_rd_arbiter.
// A behavioural ROM with RD_LAT latency feeds the DUT.
// Each test task pushes expected ROM addresses and response beats into
// queues. A negedge monitor pops and compares them as the DUT produces them.
// Grant order under contention follows ROM_ARB_RR_EN.
module tb_rom_rd_arbiter #(
    parameter int RD_LAT = 2
);

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
    } addr_exp_t;

    typedef struct {
        int          cyc;
        int          owner;
        logic [63:0] data;
    } rsp_exp_t;

    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [9:0]  req0_addr, req1_addr;
    logic [3:0]  req0_len, req1_len;
    logic        rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_data, rsp1_data;
    logic [9:0]  rom_addr;
    logic [63:0] rom_rd_data;
    logic        busy;

    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    addr_exp_t   addr_q[$];
    rsp_exp_t    rsp_q[$];
    int          mon_owner;
    logic [63:0] mon_data;
    logic [9:0]  rom_pipe [RD_LAT];

    rom_rd_arbiter #(
        .ADDR_W(10),
        .DATA_W(64),
        .RD_LAT(RD_LAT)
    ) dut (
        .rd_clk      (rd_clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_len    (req0_len),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_len    (req1_len),
        .rsp0_valid  (rsp0_valid),
        .rsp0_data   (rsp0_data),
        .rsp1_valid  (rsp1_valid),
        .rsp1_data   (rsp1_data),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .busy        (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // Cycle counter; a task reading cyc after a posedge sees the current cycle.
    always @(posedge rd_clk) cyc <= cyc + 1;

    // Each word's contents encode its own address, so misordered beats show.
    function automatic logic [63:0] rom_word(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a, ~{22'd0, a}};
    endfunction

    // Behavioural ROM: the address is registered RD_LAT times before the data.
    always @(posedge rd_clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_rd_data = rom_word(rom_pipe[RD_LAT-1]);

    // Scoreboard monitor.
    // Checks the expected ROM address in its cycle.
    // Flags beats that never came.
    // Checks every response against the head of the response queue.
    always @(negedge rd_clk) begin
        if (rst_n) begin
            if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
                checks++;
                if (rom_addr !== addr_q[0].addr) begin
                    errors++;
                    $display("[TB] FAIL rom_addr cyc=%0d got=%h want=%h", cyc, rom_addr, addr_q[0].addr);
                end
                void'(addr_q.pop_front());
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL rsp_missing want_cyc=%0d owner=%0d now=%0d", rsp_q[0].cyc, rsp_q[0].owner, cyc);
                void'(rsp_q.pop_front());
            end
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected cyc=%0d got v0=%b v1=%b want none", cyc, rsp0_valid, rsp1_valid);
                end else begin
                    mon_owner = rsp1_valid ? 1 : 0;
                    mon_data  = rsp1_valid ? rsp1_data : rsp0_data;
                    if ((rsp0_valid && rsp1_valid) || mon_owner != rsp_q[0].owner || mon_data !== rsp_q[0].data) begin
                        errors++;
                        $display("[TB] FAIL rsp_beat cyc=%0d got v0=%b v1=%b data=%h want owner=%0d data=%h",
                                 cyc, rsp0_valid, rsp1_valid, mon_data, rsp_q[0].owner, rsp_q[0].data);
                    end
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    // Drive one requester's fields and raise its valid.
    task automatic applyStimulus(input int n, input logic [9:0] addr, input logic [3:0] len);
        if (n == 0) begin
            req0_addr = addr; req0_len = len; req0_valid = 1'b1;
        end else begin
            req1_addr = addr; req1_len = len; req1_valid = 1'b1;
        end
    endtask

    // Queue expectations for a burst accepted in cycle t.
    task automatic push_burst(input int owner, input logic [9:0] addr, input logic [3:0] len, input int t);
        logic [9:0] a;
        for (int k = 0; k <= int'(len); k++) begin
            a = addr + 10'(k);
            addr_q.push_back('{t + 1 + k, a});
            rsp_q.push_back('{t + 1 + RD_LAT + k, owner, rom_word(a)});
        end
    endtask

    // Wait until the DUT is idle and every expected beat has been seen.
    task automatic wait_idle(input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge rd_clk);
            if (busy === 1'b0 && rsp_q.size() == 0 && addr_q.size() == 0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL drain_timeout busy=%b pending_rsp=%0d want idle", busy, rsp_q.size());
        end
        @(posedge rd_clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
        repeat (3) @(posedge rd_clk);
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready got=%b want=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready got=%b want=0", req1_ready); end
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp0_valid got=%b want=0", rsp0_valid); end
        checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp1_valid got=%b want=0", rsp1_valid); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_rom_addr got=%h want=000", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // The request arrives in the same cycle reset is released.
    // It must be accepted on the very next edge.
    task automatic test_single_burst();
        int t;
        int last;
        applyStimulus(0, 10'h010, 4'd3);
        @(negedge rd_clk);
        t = cyc;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL single_grant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        push_burst(0, 10'h010, 4'd3, t);
        @(posedge rd_clk); #1;
        req0_valid = 1'b0; req0_addr = 10'h3AA; req0_len = 4'd15;
        @(negedge rd_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_burst got=%b want=1", busy); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_in_burst got=%b want=0", req0_ready); end
        last = t + 1 + RD_LAT + 3;
        while (cyc < last) @(negedge rd_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_last_beat got=%b want=1", busy); end
        @(negedge rd_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_last got=%b want=0", busy); end
        wait_idle(40);
        checks++; if (rom_addr !== 10'h013) begin errors++; $display("[TB] FAIL rom_addr_hold got=%h want=013", rom_addr); end
    endtask

    task automatic test_wrap();
        applyStimulus(1, 10'h3FE, 4'd3);
        @(negedge rd_clk);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_grant got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
        end
        push_burst(1, 10'h3FE, 4'd3, cyc);
        @(posedge rd_clk); #1;
        req1_valid = 1'b0;
        wait_idle(40);
    endtask

    // Both requesters hold valid with single-word bursts.
    // In the round-robin build, requester 1 won last (wrap test), so the
    // order is 0,1,0,1. In the fixed-priority build, 0 wins every time.
    task automatic test_contention();
        int exp_n;
        applyStimulus(0, 10'h100, 4'd0);
        applyStimulus(1, 10'h200, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk);
`ifdef ROM_ARB_RR_EN
            exp_n = i % 2;
`else
            exp_n = 0;
`endif
            checks++;
            if (req0_ready !== (exp_n == 0) || req1_ready !== (exp_n == 1)) begin
                errors++; $display("[TB] FAIL contention_grant%0d got r0=%b r1=%b want req%0d", i, req0_ready, req1_ready, exp_n);
            end
            push_burst(exp_n, (exp_n == 0) ? 10'h100 : 10'h200, 4'd0, cyc);
            @(negedge rd_clk);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL contention_bubble%0d got r0=%b r1=%b want 0 0", i, req0_ready, req1_ready);
            end
        end
        @(posedge rd_clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(40);
    endtask

    // A 16-word burst from 0 with 1 pending.
    // Requester 1 sees ready first 17 cycles after the first acceptance.
    task automatic test_back_to_back();
        int t;
        int early = 0;
        applyStimulus(0, 10'h050, 4'd15);
        applyStimulus(1, 10'h0A0, 4'd2);
        @(negedge rd_clk);
        t = cyc;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_first_grant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        push_burst(0, 10'h050, 4'd15, t);
        @(posedge rd_clk); #1;
        req0_valid = 1'b0;
        for (int c = 1; c < 17; c++) begin
            @(negedge rd_clk);
            if (req1_ready !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("[TB] FAIL b2b_ready_early got=%0d cycles want=0", early); end
        @(negedge rd_clk);
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_t17 got=%b want=1", req1_ready); end
        push_burst(1, 10'h0A0, 4'd2, t + 17);
        @(posedge rd_clk); #1;
        req1_valid = 1'b0;
        wait_idle(60);
    endtask

    task automatic test_reset_mid_burst();
        int quiet = 0;
        applyStimulus(0, 10'h123, 4'd7);
        @(negedge rd_clk);
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_grant got=%b want=1", req0_ready); end
        push_burst(0, 10'h123, 4'd7, cyc);
        @(posedge rd_clk); #1;
        req0_valid = 1'b0;
        @(posedge rd_clk);
        @(posedge rd_clk); #1;
        addr_q.delete();
        rsp_q.delete();
        rst_n = 1'b0;
        applyStimulus(1, 10'h077, 4'd1);
        #1;
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("[TB] FAIL midrst_rom_addr got=%h want=000", rom_addr); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_valid got=%b%b want=00", rsp0_valid, rsp1_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready got=%b want=0", req1_ready); end
        repeat (3) begin
            @(negedge rd_clk);
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) quiet++;
        end
        checks++; if (quiet != 0) begin errors++; $display("[TB] FAIL midrst_quiet got=%0d active cycles want=0", quiet); end
        @(posedge rd_clk); #1;
        rst_n = 1'b1;
        @(negedge rd_clk);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_grant got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
        end
        push_burst(1, 10'h077, 4'd1, cyc);
        @(posedge rd_clk); #1;
        req1_valid = 1'b0;
        wait_idle(40);
    endtask

    initial begin
        $display("[TB] rom_rd_arbiter bench, RD_LAT=%0d", RD_LAT);
        test_reset();
        test_single_burst();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_rd_arbiter.md
ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, ROM word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 64, ROM data width.
REQ-003 SHALL have parameter RD_LAT, default 2, ROM read latency in cycles from rom_addr to rom_rd_data (legal 1..4).
REQ-004 SHALL have port rd_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports reqN_valid / reqN_ready  in / out  1  burst request handshake, N=0,1.
REQ-007 SHALL have ports reqN_addr  in  ADDR_W  burst start address, N=0,1.
REQ-008 SHALL have ports reqN_len  in  4  burst length minus one (0 = 1 word, 15 = 16 words), N=0,1.
REQ-009 SHALL have ports rspN_valid / rspN_data  out  1 / DATA_W  read data to requester N, N=0,1.
REQ-010 SHALL have port rom_addr  out  ADDR_W  registered address to ROM.
REQ-011 SHALL have port rom_rd_data  in  DATA_W  ROM read data.
REQ-012 SHALL have port busy  out  1  high while FSM is in BURST or responses are in flight.

Function
REQ-013 SHALL implement FSM with states IDLE and BURST; owner register (0/1) and beat counter (4 bits).
REQ-014 SHALL assert reqN_ready combinationally only in IDLE and only for the requester selected by arbitration; at most one ready high per cycle.
REQ-015 SHALL accept a request on reqN_valid & reqN_ready (cycle T), latch addr/len, set owner=N, go to BURST.
REQ-016 SHALL drive rom_addr = start+k at cycle T+1+k, k = 0..len, one beat per cycle, no gaps.
REQ-017 SHALL wrap address modulo 2^ADDR_W (1023 -> 0 at default width).
REQ-018 SHALL return to IDLE at cycle T+2+len; earliest next acceptance is T+2+len (one-cycle bubble between bursts).
REQ-019 SHALL carry owner tag and issue-valid through an RD_LAT-deep shift pipeline aligned with the ROM.
REQ-020 SHALL assert rsp<owner>_valid for exactly one cycle per beat at T+1+RD_LAT+k with rsp<owner>_data = rom_rd_data that cycle; the other rsp valid stays low.
REQ-021 SHALL drive rspN_data from rom_rd_data unconditionally; data is meaningful only while rspN_valid is high.
REQ-022 SHALL have no response backpressure; requesters consume every valid beat.
REQ-023 SHALL hold rom_addr at its last value when no beat is issued.
REQ-024 SHALL ignore reqN_addr/reqN_len changes after acceptance; a requester whose valid drops before ready is simply not served.
REQ-025 SHALL deassert busy the cycle after the last rspN_valid of the final burst when FSM is IDLE and pipeline empty.

Reset
REQ-026 SHALL on rst_n low, asynchronously: state=IDLE, owner=0, counter=0, rom_addr=0, pipeline valids=0, rspN_valid=0, reqN_ready=0 until rst_n high, busy=0, last_grant=1.
REQ-027 SHALL abort a burst on reset mid-operation; no rspN_valid asserted for beats issued before reset.
REQ-028 SHALL accept requests from the first rd_clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro ROM_ARB_RR_EN defined, arbitrate round-robin on contention: grant the requester not granted last (last_grant updated on each acceptance); single valid requester always granted.
REQ-030 SHALL, without ROM_ARB_RR_EN, use fixed priority: requester 0 wins whenever req0_valid is high in IDLE; last_grant register absent.

Verification
REQ-031 SHALL verify single burst: req0 addr=0x010 len=3 at T -> rom_addr 0x010..0x013 at T+1..T+4, rsp0_valid at T+3..T+6 (RD_LAT=2) with ROM words 0x010..0x013, rsp1_valid never high.
REQ-032 SHALL verify wrap: req1 addr=0x3FE len=3 -> rom_addr 0x3FE,0x3FF,0x000,0x001, four rsp1 beats in order.
REQ-033 SHALL verify contention: req0 and req1 held valid with len=0 -> RR build grants 0,1,0,1 each two cycles apart; fixed build grants 0 every acceptance, req1 starved.
REQ-034 SHALL verify back-to-back: req0 len=15 then req1 pending -> req1_ready first high at T+17, 16 contiguous rsp0 beats then rsp1 beats after one-cycle gap.
REQ-035 SHALL verify reset mid-burst: rst_n low at T+3 of len=7 burst -> all outputs at reset values immediately, no further rsp valid, new request after release served normally.
REQ-036 SHALL verify RD_LAT=1 and RD_LAT=4 builds: rsp timing shifts to T+2+k and T+5+k respectively.
